// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, reset-cause
// encodings and the width of the phase/debounce counters.
package reset_seq_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ASSERT     = 2'd1,
      ST_REL_PERIPH = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_BTN  = 2'b01;
   localparam logic [1:0] CAUSE_SOFT = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Reset-button conditioner: 2-flop synchronizer, saturating low-run counter and
// re-arm logic, producing a registered one-cycle press event per accepted press.
module btn_debounce
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic press
);

   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] low_cnt;
   logic             armed;
   logic             reach;

   // The counter reaches LIMIT on this edge: the press is "first seen" exactly once.
   assign reach = !sync_p1 && (low_cnt == LIMIT_M1);

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         low_cnt <= '0;
         armed   <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_p0 <= btn_i;
         sync_p1 <= sync_p0;
         press   <= reach && armed;
         if (sync_p1) begin
            low_cnt <= '0;
            armed   <= 1'b1;
         end else begin
            if (low_cnt != LIMIT) low_cnt <= low_cnt + ONE;
            if (reach && armed) armed <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds peripheral and CPU resets, then releases the
// peripherals first and the CPU GAP_CYC later. SOFT_RESET_EN enables soft_req_i.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16,
   parameter int HOLD_CYC     = 8,
   parameter int GAP_CYC      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_i,
   input  logic       soft_req_i,
   output logic       periph_rst_o,
   output logic       cpu_rst_o,
   output logic       seq_busy_o,
   output logic [1:0] rst_cause_o,
   output logic [7:0] reset_cnt_o
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] phase_cnt;
   logic             press;
   logic             soft_go;

   btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_debounce (
      .clock (clock),
      .reset (reset),
      .btn_i (btn_i),
      .press (press)
   );

`ifdef SOFT_RESET_EN
   assign soft_go = soft_req_i;
`else
   logic unused_soft;
   assign unused_soft = soft_req_i;
   assign soft_go     = 1'b0;
`endif

   // Phase counters are loaded with length-1 on entry and leave the state at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_ASSERT;
         phase_cnt    <= HOLD_LOAD;
         periph_rst_o <= 1'b1;
         cpu_rst_o    <= 1'b1;
         seq_busy_o   <= 1'b1;
         rst_cause_o  <= CAUSE_POR;
         reset_cnt_o  <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (press || soft_go) begin
                  state        <= ST_ASSERT;
                  phase_cnt    <= HOLD_LOAD;
                  periph_rst_o <= 1'b1;
                  cpu_rst_o    <= 1'b1;
                  seq_busy_o   <= 1'b1;
                  rst_cause_o  <= press ? CAUSE_BTN : CAUSE_SOFT;
                  reset_cnt_o  <= reset_cnt_o + 8'd1;
               end
            end
            ST_ASSERT: begin
               if (phase_cnt == '0) begin
                  state        <= ST_REL_PERIPH;
                  phase_cnt    <= GAP_LOAD;
                  periph_rst_o <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt - ONE;
               end
            end
            ST_REL_PERIPH: begin
               if (phase_cnt == '0) begin
                  state      <= ST_IDLE;
                  cpu_rst_o  <= 1'b0;
                  seq_busy_o <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt - ONE;
               end
            end
            default: begin
               state        <= ST_IDLE;
               periph_rst_o <= 1'b0;
               cpu_rst_o    <= 1'b0;
               seq_busy_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: power-on table, hand-written button/soft/reset
// sequences, counter wrap and random stimulus against a time-based model.
module tb_reset_sequencer;

   localparam int D = 16;
   localparam int H = 8;
   localparam int G = 4;
`ifdef SOFT_RESET_EN
   localparam bit SOFT_EN = 1'b1;
`else
   localparam bit SOFT_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_i = 1'b1;
   logic       soft_req_i = 1'b0;
   logic       periph_rst_o;
   logic       cpu_rst_o;
   logic       seq_busy_o;
   logic [1:0] rst_cause_o;
   logic [7:0] reset_cnt_o;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   reset_sequencer #(
      .DEBOUNCE_CYC(D),
      .HOLD_CYC    (H),
      .GAP_CYC     (G)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn_i       (btn_i),
      .soft_req_i  (soft_req_i),
      .periph_rst_o(periph_rst_o),
      .cpu_rst_o   (cpu_rst_o),
      .seq_busy_o  (seq_busy_o),
      .rst_cause_o (rst_cause_o),
      .reset_cnt_o (reset_cnt_o)
   );

   // Model: time since the sequence started decides the outputs; button is a
   // delayed copy of btn_i whose low-run length is tracked.
   bit m_s1 = 1'b1, m_s2 = 1'b1, m_armed = 1'b0, m_press = 1'b0;
   int m_run = 0, m_elapsed = 0, m_cause = 0, m_cnt = 0;

   always @(posedge clock) begin : model
      int new_run;
      bit press_next;
      if (reset) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0; m_armed = 1'b0; m_press = 1'b0;
         m_elapsed = 0; m_cause = 0; m_cnt = 0;
      end else begin
         if (m_elapsed >= H + G) begin
            if (m_press || (SOFT_EN && soft_req_i)) begin
               m_elapsed = 0;
               m_cause   = m_press ? 1 : 2;
               m_cnt     = (m_cnt + 1) % 256;
            end
         end else begin
            m_elapsed++;
         end
         new_run    = m_s2 ? 0 : ((m_run + 1 > D) ? D : m_run + 1);
         press_next = m_armed && !m_s2 && (m_run < D) && (new_run == D);
         if (m_s2) m_armed = 1'b1;
         else if (press_next) m_armed = 1'b0;
         m_press = press_next;
         m_run   = new_run;
         m_s2    = m_s1;
         m_s1    = btn_i;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic check_model();
      chk("m_periph", 32'(periph_rst_o), 32'(m_elapsed < H));
      chk("m_cpu",    32'(cpu_rst_o),    32'(m_elapsed < H + G));
      chk("m_busy",   32'(seq_busy_o),   32'(m_elapsed < H + G));
      chk("m_cause",  32'(rst_cause_o),  32'(m_cause));
      chk("m_cnt",    32'(reset_cnt_o),  32'(m_cnt));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
         check_model();
      end
   endtask

   typedef struct {
      bit rst;
      bit ep;
      bit ec;
      bit eb;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input bit r, input bit p, input bit c, input bit b);
      vec_t v;
      v.rst = r; v.ep = p; v.ec = c; v.eb = b;
      tbl.push_back(v);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int exp_cnt;
      bit found;

      // Power-on: 3 reset cycles, then 8 ASSERT, 4 REL_PERIPH, IDLE; then a
      // second reset that is re-applied while in REL_PERIPH.
      repeat (3) add(1, 1, 1, 1);
      for (int n = 1; n <= 7; n++) add(0, 1, 1, 1);
      for (int n = 8; n <= 11; n++) add(0, 0, 1, 1);
      for (int n = 12; n <= 14; n++) add(0, 0, 0, 0);
      add(1, 1, 1, 1);
      for (int n = 1; n <= 7; n++) add(0, 1, 1, 1);
      add(0, 0, 1, 1);
      add(1, 1, 1, 1);

      foreach (tbl[i]) begin
         reset = tbl[i].rst;
         @(posedge clock);
         #1;
         chk($sformatf("tbl%0d_periph", i), 32'(periph_rst_o), 32'(tbl[i].ep));
         chk($sformatf("tbl%0d_cpu", i),    32'(cpu_rst_o),    32'(tbl[i].ec));
         chk($sformatf("tbl%0d_busy", i),   32'(seq_busy_o),   32'(tbl[i].eb));
         chk($sformatf("tbl%0d_cause", i),  32'(rst_cause_o),  32'd0);
         chk($sformatf("tbl%0d_cnt", i),    32'(reset_cnt_o),  32'd0);
      end
      reset = 1'b0;
      step(H + G + 2);

      // Button press: latency from first low drive to cpu reset assertion.
      btn_i = 1'b0;
      lat = 0;
      while (!cpu_rst_o && lat < 100) begin
         step(1);
         lat++;
      end
      tests++;
      if (lat < D + 2 || lat > D + 4) begin
         fails++;
         $display("FAIL press_latency got=%0d exp=%0d..%0d", lat, D + 2, D + 4);
      end
      step(40 - lat);
      chk("press_cause", 32'(rst_cause_o), 32'd1);
      chk("press_cnt",   32'(reset_cnt_o), 32'd1);
      step(160);
      chk("hold_cnt",    32'(reset_cnt_o), 32'd1);
      btn_i = 1'b1;
      step(20);
      chk("hold_rel_cnt",  32'(reset_cnt_o), 32'd1);
      chk("hold_rel_busy", 32'(seq_busy_o),  32'd0);
      exp_cnt = 1;

      // Bounce: two short low runs separated by one high cycle.
      btn_i = 1'b0; step(10);
      btn_i = 1'b1; step(1);
      btn_i = 1'b0; step(10);
      btn_i = 1'b1; step(30);
      chk("bounce_cnt",  32'(reset_cnt_o), 32'(exp_cnt));
      chk("bounce_busy", 32'(seq_busy_o),  32'd0);

      // Soft request in IDLE, then a second one during ASSERT.
      soft_req_i = 1'b1; step(1); soft_req_i = 1'b0;
      if (SOFT_EN) begin
         exp_cnt++;
         chk("soft_busy",  32'(seq_busy_o),  32'd1);
         chk("soft_cause", 32'(rst_cause_o), 32'd2);
      end else begin
         chk("soft_off_busy",  32'(seq_busy_o),  32'd0);
         chk("soft_off_cause", 32'(rst_cause_o), 32'd1);
      end
      chk("soft_cnt", 32'(reset_cnt_o), 32'(exp_cnt));
      step(3);
      soft_req_i = 1'b1; step(1); soft_req_i = 1'b0;
      step(20);
      chk("soft_busy_ignored_cnt", 32'(reset_cnt_o), 32'(exp_cnt));

      // Collision: soft pulse in the same cycle as the press event.
      btn_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1);
         if (m_press) found = 1'b1;
      end
      chk("collide_found", 32'(found), 32'd1);
      soft_req_i = 1'b1; step(1); soft_req_i = 1'b0;
      exp_cnt++;
      chk("collide_cause", 32'(rst_cause_o), 32'd1);
      chk("collide_cnt",   32'(reset_cnt_o), 32'(exp_cnt));
      btn_i = 1'b1;
      step(20);

      // Mid-sequence reset while in REL_PERIPH.
      btn_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step(1);
         if (!periph_rst_o && cpu_rst_o) found = 1'b1;
      end
      chk("mid_found", 32'(found), 32'd1);
      btn_i = 1'b1;
      reset = 1'b1; step(1); reset = 1'b0;
      chk("mid_periph", 32'(periph_rst_o), 32'd1);
      chk("mid_cpu",    32'(cpu_rst_o),    32'd1);
      chk("mid_busy",   32'(seq_busy_o),   32'd1);
      chk("mid_cause",  32'(rst_cause_o),  32'd0);
      chk("mid_cnt",    32'(reset_cnt_o),  32'd0);
      step(20);

      // Counter wrap: 256 button sequences from zero.
      for (int s = 1; s <= 256; s++) begin
         btn_i = 1'b0; step(24);
         btn_i = 1'b1; step(16);
         if (s == 255) chk("wrap_255", 32'(reset_cnt_o), 32'd255);
      end
      chk("wrap_0",     32'(reset_cnt_o), 32'd0);
      chk("wrap_cause", 32'(rst_cause_o), 32'd1);

      // Random: long and short button runs, sparse soft pulses and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) btn_i = ~btn_i;
         soft_req_i = ($urandom_range(0, 39) == 0);
         reset      = ($urandom_range(0, 799) == 0);
         step(1);
      end
      reset = 1'b0; soft_req_i = 1'b0; btn_i = 1'b1;
      step(30);
      chk("final_busy", 32'(seq_busy_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
